// File: rtl/c128_bus_pkg.sv
// Shared C128 system-bus definitions: master FSM states, bus direction
// encoding and the MMU register address windows.
package c128_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } bus_state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam logic [15:0] MMU_CR_D500       = 16'hD500;
    localparam logic [15:0] MMU_LAST_D50B     = 16'hD50B;
    localparam logic [15:0] MMU_CR_FF00       = 16'hFF00;
    localparam logic [15:0] MMU_LCR_LAST_FF04 = 16'hFF04;

    // True when an address falls in either MMU register window.
    function automatic logic is_mmu_addr(input logic [15:0] a);
        return ((a >= MMU_CR_D500) && (a <= MMU_LAST_D50B)) ||
               ((a >= MMU_CR_FF00) && (a <= MMU_LCR_LAST_FF04));
    endfunction

endpackage

// File: rtl/mmu_bus_master.sv
// Single-transaction C128 bus initiator used to program and read back the
// MMU registers. One command in flight: ADDR, HOLD_CYCLES of DATA, DONE.
// Optional build macro MMU_MASTER_RDY_EN: DATA is stretched while rdy_in is
// low once the hold counter has expired. Without it rdy_in is ignored.
module mmu_bus_master
    import c128_bus_pkg::*;
#(
    parameter int          HOLD_CYCLES = 2,
    parameter logic [15:0] PARK_ADDR   = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic [15:0] addr_out,
    output logic        rw_out,
    inout  wire  [7:0]  d_d,
    input  logic        rdy_in
);

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    bus_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [15:0] addr_out_q, addr_out_d;
    logic        rw_out_q, rw_out_d;
    logic        oe_q, oe_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        ready_en_q, ready_en_d;
    logic        data_adv;

`ifdef MMU_MASTER_RDY_EN
    assign data_adv = rdy_in;
`else
    logic unused_rdy;
    assign unused_rdy = rdy_in;
    assign data_adv   = 1'b1;
`endif

    // ready_en_q keeps cmd_ready low until one clean edge after reset release.
    assign cmd_ready = (state_q == IDLE) && ready_en_q && reset_in;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign addr_out  = addr_out_q;
    assign rw_out    = rw_out_q;
    assign d_d       = oe_q ? wdata_q : 8'hzz;

    // Next-state and registered bus-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        addr_out_d  = addr_out_q;
        rw_out_d    = rw_out_q;
        oe_d        = oe_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        ready_en_d  = 1'b1;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d    = ADDR;
                    wr_d       = cmd_write;
                    wdata_d    = cmd_wdata;
                    addr_out_d = cmd_addr;
                    rw_out_d   = cmd_write;
                    oe_d       = (cmd_write == RW_WRITE);
                end
            end
            ADDR: begin
                state_d = DATA;
                cnt_d   = HOLD_LOAD;
            end
            DATA: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (data_adv) begin
                    // Bus is parked and released in the same edge that samples.
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    if (wr_q == RW_READ) rsp_rdata_d = d_d;
                    addr_out_d  = PARK_ADDR;
                    rw_out_d    = RW_READ;
                    oe_d        = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction and parks the bus.
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= RW_READ;
            wdata_q     <= 8'h00;
            addr_out_q  <= PARK_ADDR;
            rw_out_q    <= RW_READ;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            addr_out_q  <= addr_out_d;
            rw_out_q    <= rw_out_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            ready_en_q  <= ready_en_d;
        end
    end

endmodule

// File: tb/tb_mmu_bus_master.sv
// Directed bench for mmu_bus_master: one HOLD_CYCLES=2 instance and one
// HOLD_CYCLES=1 instance, each with its own pulled-down data bus and a
// bench-side target that drives read data when addressed with rw_out=0.
module tb_mmu_bus_master;

    logic        clk = 1'b0;
    logic        reset_in = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = 16'h0000;
    logic [7:0]  cmd_wdata = 8'h00;
    logic        rdy_in = 1'b1;
    logic        sel = 1'b0;

    logic [15:0] drv_addr = 16'h1234;
    logic [7:0]  drv_data = 8'h00;

    logic        rdy0, rv0, busy0, rw0;
    logic [7:0]  rd0;
    logic [15:0] addr0;
    wire  [7:0]  bus0;
    logic        rdy1, rv1, busy1, rw1;
    logic [7:0]  rd1;
    logic [15:0] addr1;
    wire  [7:0]  bus1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 8; i++) begin : g_pd
        pulldown pd0 (bus0[i]);
        pulldown pd1 (bus1[i]);
    end

    assign bus0 = (!rw0 && addr0 == drv_addr) ? drv_data : 8'hzz;
    assign bus1 = (!rw1 && addr1 == drv_addr) ? drv_data : 8'hzz;

    mmu_bus_master #(.HOLD_CYCLES(2), .PARK_ADDR(16'h0000)) dut0 (
        .clk(clk), .reset_in(reset_in), .cmd_valid(cmd_valid && !sel), .cmd_ready(rdy0),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0), .busy(busy0), .addr_out(addr0),
        .rw_out(rw0), .d_d(bus0), .rdy_in(rdy_in)
    );

    mmu_bus_master #(.HOLD_CYCLES(1), .PARK_ADDR(16'h0000)) dut1 (
        .clk(clk), .reset_in(reset_in), .cmd_valid(cmd_valid && sel), .cmd_ready(rdy1),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1), .busy(busy1), .addr_out(addr1),
        .rw_out(rw1), .d_d(bus1), .rdy_in(rdy_in)
    );

    wire        o_ready = sel ? rdy1  : rdy0;
    wire        o_rv    = sel ? rv1   : rv0;
    wire [7:0]  o_rd    = sel ? rd1   : rd0;
    wire        o_busy  = sel ? busy1 : busy0;
    wire [15:0] o_addr  = sel ? addr1 : addr0;
    wire        o_rw    = sel ? rw1   : rw0;
    wire [7:0]  o_bus   = sel ? bus1  : bus0;

    typedef struct {
        logic        sel;
        int          hold;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  bus_data;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'd1);
    endtask

    // Full transaction with per-cycle bus checks; returns at the idle negedge.
    task automatic run_txn(input vec_t v);
        logic [7:0] exp_bus;
        sel      = v.sel;
        drv_addr = v.addr;
        drv_data = v.bus_data;
        exp_bus  = v.wr ? v.wdata : v.bus_data;
        wait_ready();
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int j = 0; j <= v.hold; j++) begin
            @(negedge clk);
            chk("phase_addr",  32'(o_addr),  32'(v.addr));
            chk("phase_rw",    32'(o_rw),    32'(v.wr));
            chk("phase_bus",   32'(o_bus),   32'(exp_bus));
            chk("phase_rsp",   32'(o_rv),    32'd0);
            chk("phase_ready", 32'(o_ready), 32'd0);
            chk("phase_busy",  32'(o_busy),  32'd1);
        end
        @(negedge clk);
        chk("done_rsp",   32'(o_rv),   32'd1);
        chk("done_rdata", 32'(o_rd),   32'(v.exp_rdata));
        chk("done_park",  32'(o_addr), 32'h0000);
        chk("done_rw",    32'(o_rw),   32'd0);
        chk("done_bus",   32'(o_bus),  32'h00);
        @(negedge clk);
        chk("idle_rsp",   32'(o_rv),    32'd0);
        chk("idle_ready", 32'(o_ready), 32'd1);
        chk("idle_busy",  32'(o_busy),  32'd0);
        drv_addr = 16'h1234;
    endtask

    initial begin
        int n, pulses, rsp_j;
        logic [7:0] rsp_val;
        vec_t v;

        vecs[0] = '{1'b0, 2, 1'b1, 16'hD500, 8'h3E, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 2, 1'b0, 16'hFF00, 8'h00, 8'h55, 8'h55};
        vecs[2] = '{1'b0, 2, 1'b1, 16'hD50B, 8'hA5, 8'h00, 8'h55};
        vecs[3] = '{1'b0, 2, 1'b0, 16'hD505, 8'h00, 8'hC3, 8'hC3};
        vecs[4] = '{1'b0, 2, 1'b1, 16'hFF04, 8'h12, 8'h00, 8'hC3};
        vecs[5] = '{1'b1, 1, 1'b1, 16'hD506, 8'hC0, 8'h00, 8'h00};

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_addr",  32'(addr0), 32'h0000);
        chk("rst_rw",    32'(rw0),   32'd0);
        chk("rst_bus",   32'(bus0),  32'h00);
        chk("rst_rsp",   32'(rv0),   32'd0);
        chk("rst_rdata", 32'(rd0),   32'h00);
        chk("rst_busy",  32'(busy0), 32'd0);
        chk("rst_ready", 32'(rdy0),  32'd0);
        reset_in = 1'b1;
        @(negedge clk);
        chk("rst_ready_rise", 32'(rdy0), 32'd1);

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Two queued commands with cmd_valid held: second accepted 5 clocks later.
        sel = 1'b0;
        wait_ready();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'hD501; cmd_wdata = 8'h11;
        @(posedge clk);
        #1 cmd_addr = 16'hD502; cmd_wdata = 8'h22;
        n = 0; pulses = 0;
        @(negedge clk);
        chk("b2b_first_addr", 32'(addr0), 32'hD501);
        while (!rdy0 && n < 20) begin
            pulses += int'(rv0);
            @(negedge clk);
            n++;
        end
        chk("b2b_interval", 32'(n + 1), 32'd5);
        chk("b2b_first_pulses", 32'(pulses), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_addr", 32'(addr0), 32'hD502);
        chk("b2b_second_bus",  32'(bus0),  32'h22);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            pulses += int'(rv0);
            @(negedge clk);
        end
        chk("b2b_second_pulses", 32'(pulses), 32'd1);
        chk("b2b_idle_busy", 32'(busy0), 32'd0);

        // Reset during the second DATA cycle of a write.
        wait_ready();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'hD500; cmd_wdata = 8'h5A;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre_bus", 32'(bus0), 32'h5A);
        reset_in = 1'b0;
        @(negedge clk);
        chk("abort_rsp",   32'(rv0),   32'd0);
        chk("abort_addr",  32'(addr0), 32'h0000);
        chk("abort_rw",    32'(rw0),   32'd0);
        chk("abort_bus",   32'(bus0),  32'h00);
        chk("abort_ready", 32'(rdy0),  32'd0);
        reset_in = 1'b1;
        @(negedge clk);
        chk("abort_ready_rise", 32'(rdy0), 32'd1);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            pulses += int'(rv0);
            @(negedge clk);
        end
        chk("abort_no_rsp", 32'(pulses), 32'd0);

        // rdy_in low for three edges at the end of DATA.
        sel = 1'b0; drv_addr = 16'hFF01; drv_data = 8'h77;
        wait_ready();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'hFF01;
        @(posedge clk);
        #1 cmd_valid = 1'b0; rdy_in = 1'b0;
        rsp_j = -1; rsp_val = 8'h00;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (rv0 && rsp_j < 0) begin
                rsp_j = j;
                rsp_val = rd0;
            end
            if (j == 5) rdy_in = 1'b1;
        end
`ifdef MMU_MASTER_RDY_EN
        chk("rdy_rsp_cycle", 32'(rsp_j), 32'd6);
`else
        chk("rdy_rsp_cycle", 32'(rsp_j), 32'd3);
`endif
        chk("rdy_rdata", 32'(rsp_val), 32'h77);
        drv_addr = 16'h1234;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mmu_bus_master.md
Name: mmu_bus_master

Overview:
- Single-transaction bus initiator for the C128 system bus; it is the master side of the register-access protocol the MMU responds to.
- Accepts one command at a time (read or write, 16-bit address, 8-bit data) over a valid/ready handshake.
- Runs one bus cycle: address phase, then a fixed-length data phase. Returns read data, or a write completion, as a single-cycle response pulse.
- Used to program MMU configuration (D500–D50B, FF00–FF04) from boot/debug logic, and to read it back.

Parameters:
- HOLD_CYCLES, 2, length of the DATA phase in clocks; legal range 1..15.
- PARK_ADDR, 16'h0000, value driven on addr_out when idle; must not decode as D500–D50B or FF00–FF04.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- reset_in  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  16  target address.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data; valid while rsp_valid is high on a read.
- busy  out  1  high in any state other than IDLE.
- addr_out  out  16  bus address.
- rw_out  out  1  bus direction: 1 = write, 0 = read, same encoding the MMU decodes.
- d_d  inout  8  bidirectional data bus.
- rdy_in  in  1  bus RDY, used only with the optional feature.

Behaviour:
- Reset (reset_in low at posedge):
  - state IDLE, addr_out = PARK_ADDR, rw_out = 0, d_d released to Z.
  - rsp_valid = 0, rsp_rdata = 8'h00, hold counter = 0.
  - cmd_ready forced to 0 while reset_in is low.
- States: IDLE → ADDR → DATA → DONE → IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready at a posedge: latch cmd_write, cmd_addr, cmd_wdata; go to ADDR.
- ADDR (1 cycle):
  - addr_out = latched addr; rw_out = latched write.
  - Writes: d_d output enable asserted, driving latched wdata.
  - Go to DATA; counter loaded with HOLD_CYCLES-1.
- DATA (HOLD_CYCLES cycles):
  - Address, rw and write data held stable.
  - Counter decrements each cycle. When it reaches 0, go to DONE at the next edge.
  - Reads: d_d is sampled into rsp_rdata at the same edge.
- DONE (1 cycle):
  - rsp_valid = 1.
  - addr_out = PARK_ADDR, rw_out = 0, d_d released.
  - Go to IDLE.
- Output registration: addr_out, rw_out and the d_d output enable are registered, so they change only at posedge and never glitch.
- Write responses: rsp_rdata keeps its previous value.
- Timing (accept edge = E0):
  - rsp_valid visible after edge E0+HOLD_CYCLES+1 and deasserted after the next edge.
  - Next command can be accepted at E0+HOLD_CYCLES+3.
  - Issue interval: HOLD_CYCLES+3 clocks. No pipelining.
- Handshake rules:
  - cmd_valid while busy: no effect. The command is not latched; the requester holds it until cmd_ready.
  - cmd_* inputs are don't-care outside the accept edge.
- Reset mid-transaction: transaction aborted, no rsp_valid, bus parked and released at that edge.
- HOLD_CYCLES = 1: DATA lasts exactly one cycle.

Optional Feature:
- Macro: MMU_MASTER_RDY_EN.
- Defined: while in DATA with the counter at 0 and rdy_in = 0, remain in DATA (bus held, no sample). Read sampling and the DONE transition occur at the first edge where the counter is 0 and rdy_in = 1. rdy_in has no effect in other states.
- Undefined: rdy_in is ignored (port kept, unconnected internally); timing is fixed as above.

Decomposition:
- Shared package c128_bus_pkg:
  - state enum (IDLE, ADDR, DATA, DONE);
  - RW_WRITE = 1, RW_READ = 0;
  - MMU address constants MMU_CR_D500 = 16'hD500, MMU_LAST_D50B = 16'hD50B, MMU_CR_FF00 = 16'hFF00, MMU_LCR_LAST_FF04 = 16'hFF04.
- Single module; the hold counter is too small to justify a sub-module.

Test Plan (all with HOLD_CYCLES = 2 unless noted):
- Write D500 = 3E: addr_out = D500, rw_out = 1, d_d = 3E for 3 cycles (ADDR + DATA); rsp_valid pulses after E0+3; bus parked at 0000/Z the same cycle.
- Read FF00 with a bench driver placing 55 on d_d while rw_out = 0: rsp_rdata = 55 with rsp_valid after E0+3; the block never drives d_d.
- cmd_valid held continuously with two commands queued: second accepted exactly 5 clocks after the first; cmd_ready low in between; no command lost or duplicated.
- reset_in low during the second DATA cycle of a write: no rsp_valid; next edge shows addr_out = 0000, rw_out = 0, d_d = Z; cmd_ready rises the first edge after reset_in returns high.
- MMU_MASTER_RDY_EN defined, read with rdy_in low for 3 cycles at DATA end: sample and rsp_valid delayed by 3 (after E0+6). Macro undefined, same stimulus: rsp_valid after E0+3.
- HOLD_CYCLES = 1, write D506 = C0: 4-clock issue interval; rsp_valid after E0+2.
